// File: rtl/phase_acc_if.sv
// rtl/phase_acc_if.sv - control and phase output bundle for the phase accumulator
interface phase_acc_if #(
  parameter int WIDTH = 16
);
  logic             clr;
  logic             add_sub;
  logic [WIDTH-1:0] D;
  logic [WIDTH:0]   Q;

  // master drives the tuning controls and observes the phase
  modport master (
    output clr,
    output add_sub,
    output D,
    input  Q
  );

  // slave is the accumulator itself
  modport slave (
    input  clr,
    input  add_sub,
    input  D,
    output Q
  );
endinterface

// File: rtl/phase_acc.sv
// rtl/phase_acc.sv - wrapping phase accumulator with wrap flag; optional input registers via PHASEACC_INREG_EN
module phase_acc #(
  parameter int WIDTH = 16
) (
  input  logic      clock,
  input  logic      reset,
  phase_acc_if.slave bus
);

  logic [WIDTH-1:0] phase;
  logic             wrap;
  logic [WIDTH:0]   next_sum;

  logic             clr_use;
  logic             add_sub_use;
  logic [WIDTH-1:0] d_use;

`ifdef PHASEACC_INREG_EN
  logic             clr_q;
  logic             add_sub_q;
  logic [WIDTH-1:0] d_q;

  // capture controls one cycle ahead of use; cleared by reset so the first post-reset update is a no-op
  always_ff @(posedge clock) begin
    if (!reset) begin
      clr_q     <= 1'b0;
      add_sub_q <= 1'b0;
      d_q       <= '0;
    end else begin
      clr_q     <= bus.clr;
      add_sub_q <= bus.add_sub;
      d_q       <= bus.D;
    end
  end

  assign clr_use     = clr_q;
  assign add_sub_use = add_sub_q;
  assign d_use       = d_q;
`else
  assign clr_use     = bus.clr;
  assign add_sub_use = bus.add_sub;
  assign d_use       = bus.D;
`endif

  // one extra bit holds the carry on add or the borrow on subtract
  always_comb begin
    next_sum = '0;
    if (add_sub_use) begin
      next_sum = {1'b0, phase} - {1'b0, d_use};
    end else begin
      next_sum = {1'b0, phase} + {1'b0, d_use};
    end
  end

  // reset beats clear beats accumulate; wrap is rewritten every update so it lasts one cycle
  always_ff @(posedge clock) begin
    if (!reset) begin
      phase <= '0;
      wrap  <= 1'b0;
    end else if (clr_use) begin
      phase <= '0;
      wrap  <= 1'b0;
    end else begin
      phase <= next_sum[WIDTH-1:0];
      wrap  <= next_sum[WIDTH];
    end
  end

  assign bus.Q = {wrap, phase};

endmodule

// File: tb/tb_phase_acc.sv
// tb/tb_phase_acc.sv - directed self-checking bench for phase_acc (either PHASEACC_INREG_EN build)
module tb_phase_acc;

  localparam int W = 16;
`ifdef PHASEACC_INREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clock;
  logic reset;

  phase_acc_if #(.WIDTH(W)) bus ();

  phase_acc #(.WIDTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;
  logic [W:0] prev_exp = '0;

  task automatic check_eq(input string tag, input logic [W:0] got, input logic [W:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d (wrap=%0d phase=%0d) exp=%0d (wrap=%0d phase=%0d)",
               tag, got, got[W], got[W-1:0], exp, exp[W], exp[W-1:0]);
    end
  endtask

  function automatic logic [W:0] qv(input logic w, input int p);
    logic [W-1:0] ph;
    ph = p[W-1:0];
    return {w, ph};
  endfunction

  // one normal edge; exp is the result this input produces, seen LAT edges later
  task automatic vec(input string tag, input logic c, input logic as, input int d, input logic [W:0] exp);
    logic [W:0] want;
    reset       = 1'b1;
    bus.clr     = c;
    bus.add_sub = as;
    bus.D       = d[W-1:0];
    @(posedge clock);
    #1;
    want = (LAT == 1) ? exp : prev_exp;
    check_eq(tag, bus.Q, want);
    prev_exp = exp;
  endtask

  // one edge with reset low; Q clears immediately whatever the other inputs say
  task automatic rst_vec(input string tag, input logic c, input logic as, input int d);
    reset       = 1'b0;
    bus.clr     = c;
    bus.add_sub = as;
    bus.D       = d[W-1:0];
    @(posedge clock);
    #1;
    check_eq(tag, bus.Q, '0);
    prev_exp = '0;
  endtask

  initial begin
    reset       = 1'b0;
    bus.clr     = 1'b0;
    bus.add_sub = 1'b0;
    bus.D       = '0;

    // reset held two edges with a live tuning word
    rst_vec("reset_0", 1'b0, 1'b0, 10000);
    rst_vec("reset_1", 1'b0, 1'b0, 10000);

    // clear then add 10000 through the wrap
    vec("clr_first", 1'b1, 1'b0, 10000, qv(0, 0));
    vec("add_10000", 1'b0, 1'b0, 10000, qv(0, 10000));
    vec("add_20000", 1'b0, 1'b0, 10000, qv(0, 20000));
    vec("add_30000", 1'b0, 1'b0, 10000, qv(0, 30000));
    vec("add_40000", 1'b0, 1'b0, 10000, qv(0, 40000));
    vec("add_50000", 1'b0, 1'b0, 10000, qv(0, 50000));
    vec("add_60000", 1'b0, 1'b0, 10000, qv(0, 60000));
    vec("add_wrap",  1'b0, 1'b0, 10000, qv(1, 4464));
    vec("add_after", 1'b0, 1'b0, 10000, qv(0, 14464));

    // subtract borrow from zero
    vec("clr_sub",   1'b1, 1'b1, 1, qv(0, 0));
    vec("sub_wrap",  1'b0, 1'b1, 1, qv(1, 65535));
    vec("sub_after", 1'b0, 1'b1, 1, qv(0, 65534));

    // reset together with clear mid-run, resume from zero, then clear alone
    rst_vec("rst_and_clr", 1'b1, 1'b0, 1000);
    vec("resume_1000", 1'b0, 1'b0, 1000, qv(0, 1000));
    vec("resume_2000", 1'b0, 1'b0, 1000, qv(0, 2000));
    vec("clr_alone",   1'b1, 1'b0, 1000, qv(0, 0));

    // direction switch every cycle around 30000
    vec("dir_10000",  1'b0, 1'b0, 10000, qv(0, 10000));
    vec("dir_20000",  1'b0, 1'b0, 10000, qv(0, 20000));
    vec("dir_30000",  1'b0, 1'b0, 10000, qv(0, 30000));
    vec("dir_add_a",  1'b0, 1'b0, 10000, qv(0, 40000));
    vec("dir_sub",    1'b0, 1'b1, 10000, qv(0, 30000));
    vec("dir_add_b",  1'b0, 1'b0, 10000, qv(0, 40000));

    // zero tuning word in both directions holds phase
    vec("d0_add", 1'b0, 1'b0, 0, qv(0, 40000));
    vec("d0_sub", 1'b0, 1'b1, 0, qv(0, 40000));

    // half-scale word toggles between 0 and 32768
    vec("half_clr", 1'b1, 1'b0, 32768, qv(0, 0));
    vec("half_up0", 1'b0, 1'b0, 32768, qv(0, 32768));
    vec("half_wr0", 1'b0, 1'b0, 32768, qv(1, 0));
    vec("half_up1", 1'b0, 1'b0, 32768, qv(0, 32768));
    vec("half_wr1", 1'b0, 1'b0, 32768, qv(1, 0));

    // first accumulate after reset shows up after LAT edges
    rst_vec("lat_rst", 1'b0, 1'b0, 0);
    vec("lat_first", 1'b0, 1'b0, 777, qv(0, 777));
    vec("lat_flush", 1'b0, 1'b0, 0, qv(0, 777));
    vec("lat_done",  1'b0, 1'b0, 0, qv(0, 777));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/phase_acc.md
PHASE_ACC -- requirements
Module: phase_acc

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the phase accumulator width in bits (minimum 2).
REQ-002 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-004 The block SHALL have port clr, input, 1 bit: synchronous clear of the accumulator, active-high.
REQ-005 The block SHALL have port add_sub, input, 1 bit: 0 = add D each cycle, 1 = subtract D each cycle.
REQ-006 The block SHALL have port D, input, WIDTH bits: unsigned phase increment (tuning word).
REQ-007 The block SHALL have port Q, output, WIDTH+1 bits: Q[WIDTH-1:0] = registered phase; Q[WIDTH] = registered wrap flag.

Function
REQ-008 The block SHALL hold an internal WIDTH-bit phase register and a 1-bit wrap register; Q SHALL be driven directly from these registers (no combinational path from inputs to Q).
REQ-009 The block SHALL apply the following update priority on each rising edge: reset low, then clr high, then accumulate.
REQ-010 When clr=1 and reset=1, the block SHALL load phase=0 and wrap=0, ignoring D and add_sub.
REQ-011 When accumulating with add_sub=0, the block SHALL set phase <= (phase + D) mod 2^WIDTH, and wrap <= carry-out of that addition.
REQ-012 When accumulating with add_sub=1, the block SHALL set phase <= (phase - D) mod 2^WIDTH, and wrap <= borrow of that subtraction (1 when D > phase).
REQ-013 The wrap flag SHALL be a one-cycle indication per wrapping update; it SHALL be 0 on any non-wrapping update.
REQ-014 The block SHALL sample D and add_sub on the same edge that performs the update; Q SHALL reflect the update one cycle after sampling.
REQ-015 add_sub SHALL be changeable on any cycle with no dead cycle; each update uses only that cycle's add_sub.
REQ-016 With D=0, phase SHALL remain constant and wrap SHALL be 0.
REQ-017 With D=2^(WIDTH-1) added from 0, phase SHALL alternate 0 and 2^(WIDTH-1), with wrap=1 on every return to 0.

Reset
REQ-018 When reset=0 at a rising edge, the block SHALL set phase=0 and wrap=0, so Q=0, regardless of clr, add_sub and D.
REQ-019 A reset asserted mid-accumulation SHALL take effect on that edge; accumulation SHALL resume from 0 on the first edge with reset=1.
REQ-020 Without a rising clock edge, Q SHALL be undefined until the first reset edge; no asynchronous behaviour is required.

Configuration
REQ-021 The block SHALL support macro PHASEACC_INREG_EN: when defined, the block SHALL register D, add_sub and clr once before use; latency from input to Q becomes 2 cycles and the input registers reset to 0 with reset.
REQ-022 When PHASEACC_INREG_EN is undefined, the block SHALL use inputs directly, with the 1-cycle latency of REQ-014.

Verification
REQ-023 Verification SHALL cover reset: WIDTH=16, hold reset=0 for 2 edges with D=10000 -> Q=0.
REQ-024 Verification SHALL cover clear then add: release reset; clr=1 for one edge, then clr=0, D=10000, add_sub=0 -> phase 10000, 20000, ..., 60000, then 4464 with Q[16]=1, then 14464 with Q[16]=0.
REQ-025 Verification SHALL cover subtract wrap: from phase 0, D=1, add_sub=1 -> phase 65535 with Q[16]=1, next 65534 with Q[16]=0.
REQ-026 Verification SHALL cover reset priority: reset=0 and clr=1 on the same edge mid-run -> Q=0; clr=1 alone mid-run -> Q=0 on the next edge.
REQ-027 Verification SHALL cover direction switch: phase 30000, D=10000, add_sub toggled each cycle -> phase 40000, 30000, 40000, with Q[16]=0 throughout.
REQ-028 Verification SHALL cover latency with PHASEACC_INREG_EN defined: the first accumulate result appears one cycle later than without the macro.
